// File: rtl/fadd_issue_ctrl.sv
// fadd_issue_ctrl: issues add/sub requests to a pipelined fadd and buffers tagged results in order
module fadd_issue_ctrl #(
  parameter int NSTAGE = 2,
  parameter int DEPTH  = 4,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x1,
  input  logic [31:0]     req_x2,
  input  logic            req_sub,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     fadd_x1,
  output logic [31:0]     fadd_x2,
  input  logic [31:0]     fadd_y,
  input  logic            fadd_ovf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_y,
  output logic            rsp_ovf,
  output logic [TAGW-1:0] rsp_tag,
  output logic            ovf_sticky,
  input  logic            ovf_clr,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + NSTAGE + 1);

  logic [31:0]       x1_q, x1_d, x2_q, x2_d;
  logic [NSTAGE-1:0] vld_q, vld_d;
  logic [TAGW-1:0]   tag_q [NSTAGE];
  logic [AW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]     cnt_q, cnt_d, infl_q, infl_d;
  logic              sticky_q, sticky_d;
  logic [31:0]       y_mem [DEPTH];
  logic              ovf_mem [DEPTH];
  logic [TAGW-1:0]   tag_mem [DEPTH];
  logic              issue, push, pop;

  function automatic logic [31:0] flush(input logic [31:0] v);
    return (v[30:23] == 8'd0) ? {v[31], 31'd0} : v;
  endfunction

  // Ready is derived from registered occupancy only, so a same-cycle pop cannot raise it.
  assign req_ready  = (cnt_q + infl_q) < CW'(DEPTH);
  assign rsp_valid  = cnt_q != '0;
  assign rsp_y      = rsp_valid ? y_mem[rptr_q] : '0;
  assign rsp_ovf    = rsp_valid & ovf_mem[rptr_q];
  assign rsp_tag    = rsp_valid ? tag_mem[rptr_q] : '0;
  assign fadd_x1    = x1_q;
  assign fadd_x2    = x2_q;
  assign ovf_sticky = sticky_q;
  assign busy       = (|vld_q) | rsp_valid;

  // Handshake decode and next-state; operand flush applies after the subtract sign flip.
  always_comb begin
    issue    = req_valid & req_ready;
    push     = vld_q[NSTAGE-1];
    pop      = rsp_valid & rsp_ready;
    x1_d     = issue ? flush(req_x1) : x1_q;
    x2_d     = issue ? flush({req_x2[31] ^ req_sub, req_x2[30:0]}) : x2_q;
    vld_d    = vld_q << 1;
    vld_d[0] = issue;
    rptr_d   = rptr_q + AW'(pop);
    wptr_d   = wptr_q + AW'(push);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    infl_d   = infl_q + CW'(issue) - CW'(push);
    sticky_d = (push & fadd_ovf) | (sticky_q & ~ovf_clr);
  end

  // Control state with asynchronous reset; in-flight work is discarded on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1_q     <= '0;
      x2_q     <= '0;
      vld_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      infl_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      vld_q    <= vld_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
      sticky_q <= sticky_d;
    end
  end

  // Tag pipeline alongside the valid bits, and result FIFO storage written at the tail.
  always_ff @(posedge clk) begin
    tag_q[0] <= req_tag;
    for (int i = 1; i < NSTAGE; i++) tag_q[i] <= tag_q[i-1];
    if (push) begin
      y_mem[wptr_q]   <= fadd_y;
      ovf_mem[wptr_q] <= fadd_ovf;
      tag_mem[wptr_q] <= tag_q[NSTAGE-1];
    end
  end
endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// tb_fadd_issue_ctrl: directed bench with an in-order scoreboard model and a behavioural fadd
module tb_fadd_issue_ctrl;
  localparam int NSTAGE = 2;
  localparam int DEPTH  = 4;
  localparam int TAGW   = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic            req_valid, req_ready, req_sub;
  logic [31:0]     req_x1, req_x2;
  logic [TAGW-1:0] req_tag;
  logic [31:0]     fadd_x1, fadd_x2;
  logic [31:0]     fadd_y = '0;
  logic            fadd_ovf = 1'b0;
  logic            rsp_valid, rsp_ready, rsp_ovf;
  logic [31:0]     rsp_y;
  logic [TAGW-1:0] rsp_tag;
  logic            ovf_sticky, ovf_clr, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  fadd_issue_ctrl #(.NSTAGE(NSTAGE), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_x1(req_x1), .req_x2(req_x2),
    .req_sub(req_sub), .req_tag(req_tag),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y), .fadd_ovf(fadd_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf),
    .rsp_tag(rsp_tag), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-precision add on normal/zero operands, truncating; bit 32 flags exponent overflow.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa, bb;
    logic [24:0] ma, mb, s;
    int e, d;
    aa = (b[30:0] > a[30:0]) ? b : a;
    bb = (b[30:0] > a[30:0]) ? a : b;
    if (aa[30:23] == 8'd0) return {1'b0, aa[31] & bb[31], 31'd0};
    ma = {2'b01, aa[22:0]};
    mb = (bb[30:23] == 8'd0) ? 25'd0 : {2'b01, bb[22:0]};
    d = int'(aa[30:23]) - int'(bb[30:23]);
    mb = (d > 24) ? 25'd0 : (mb >> d);
    s = (aa[31] == bb[31]) ? ma + mb : ma - mb;
    e = int'(aa[30:23]);
    if (s == 25'd0) return 33'd0;
    if (s[24]) begin s = s >> 1; e++; end
    while (!s[23]) begin s = s << 1; e--; end
    if (e >= 255) return {1'b1, aa[31], 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, aa[31], 31'd0};
    return {1'b0, aa[31], e[7:0], s[22:0]};
  endfunction

  function automatic logic [31:0] ftz(input logic [31:0] v);
    return (v[30:23] == 8'd0) ? {v[31], 31'd0} : v;
  endfunction

  // Behavioural fadd: operands presented after edge k are sampled by the DUT at edge k+2.
  always @(posedge clk) {fadd_ovf, fadd_y} <= fp_add(fadd_x1, fadd_x2);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0]     y;
    logic            ovf;
    logic [TAGW-1:0] tag;
    int              due;
  } ent_t;
  ent_t q[$];
  logic stk = 1'b0;

  // Scoreboard: every request accepted is outstanding until popped, visible NSTAGE edges after issue.
  always @(negedge clk) begin
    logic ev, setv, acc;
    logic [32:0] r;
    if (!rstn) begin
      q.delete();
      stk = 1'b0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_sticky", ovf_sticky, 0);
    end else begin
      ev = q.size() > 0 && q[0].due <= cyc;
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_y", rsp_y, q[0].y);
        chk("rsp_ovf", rsp_ovf, q[0].ovf);
        chk("rsp_tag", rsp_tag, q[0].tag);
      end
      chk("req_ready", req_ready, q.size() < DEPTH);
      chk("busy", busy, q.size() > 0);
      chk("ovf_sticky", ovf_sticky, stk);
      if (dut.vld_q[NSTAGE-1] && int'(dut.cnt_q) == DEPTH && !(rsp_valid && rsp_ready)) begin
        fails++;
        $display("FAIL push_on_full got push with count %0d expected no push", DEPTH);
      end
      setv = 1'b0;
      foreach (q[i]) if (q[i].due == cyc + 1 && q[i].ovf) setv = 1'b1;
      stk = setv | (stk & !ovf_clr);
      acc = req_valid && q.size() < DEPTH;
      if (ev && rsp_ready) void'(q.pop_front());
      if (acc) begin
        r = fp_add(ftz(req_x1), ftz({req_x2[31] ^ req_sub, req_x2[30:0]}));
        q.push_back('{r[31:0], r[32], req_tag, cyc + 1 + NSTAGE});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] b, input logic s, input int t);
    req_x1 = a; req_x2 = b; req_sub = s; req_tag = TAGW'(t); req_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int idx, nxt, ntag, guard;
    logic acc;
    logic [TAGW-1:0] got [6];
    rstn = 1'b0; req_valid = 1'b0; req_x1 = '0; req_x2 = '0; req_sub = 1'b0; req_tag = '0;
    rsp_ready = 1'b1; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_fadd_x1", fadd_x1, 32'h0);
    chk("rst_fadd_x2", fadd_x2, 32'h0);
    chk("rst_rsp_y", rsp_y, 32'h0);
    chk("rst_rsp_tag", rsp_tag, 0);
    rstn = 1'b1;
    #1 chk("ready_after_rst", req_ready, 1);
    tick();
    // add 1.0 + 2.0
    req(32'h3F800000, 32'h40000000, 1'b0, 3);
    tick(); req_valid = 1'b0;
    chk("add_fadd_x1", fadd_x1, 32'h3F800000);
    chk("add_fadd_x2", fadd_x2, 32'h40000000);
    tick();
    chk("add_no_early_valid", rsp_valid, 0);
    tick();
    chk("add_valid", rsp_valid, 1);
    chk("add_y", rsp_y, 32'h40400000);
    chk("add_tag", rsp_tag, 3);
    chk("add_ovf", rsp_ovf, 0);
    tick(); tick();
    // sub 3.0 - 1.0
    req(32'h40400000, 32'h3F800000, 1'b1, 7);
    tick(); req_valid = 1'b0;
    chk("sub_fadd_x2", fadd_x2, 32'hBF800000);
    tick(); tick();
    chk("sub_y", rsp_y, 32'h40000000);
    tick(); tick();
    // backpressure: only DEPTH outstanding accepted
    rsp_ready = 1'b0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      req(32'h3F800000, 32'h40000000 + (idx << 20), 1'b0, idx);
      nxt = req_ready ? idx + 1 : idx;
      tick();
      idx = nxt;
    end
    req_valid = 1'b0;
    chk("bp_accepted", idx, 4);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1; ntag = 0; guard = 0;
    while ((idx < 6 || ntag < 6) && guard < 60) begin
      if (idx < 6) req(32'h3F800000, 32'h40000000 + (idx << 20), 1'b0, idx);
      else req_valid = 1'b0;
      acc = req_valid && req_ready;
      if (rsp_valid && rsp_ready && ntag < 6) begin got[ntag] = rsp_tag; ntag++; end
      tick();
      if (acc) idx++;
      guard++;
    end
    req_valid = 1'b0;
    chk("bp_all_returned", ntag, 6);
    for (int i = 0; i < ntag; i++) chk($sformatf("bp_order_%0d", i), got[i], i);
    tick();
    // overflow and sticky flag
    req(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 9);
    tick(); req_valid = 1'b0;
    tick(); tick();
    chk("ovf_rsp_ovf", rsp_ovf, 1);
    chk("ovf_rsp_y", rsp_y, 32'h7F800000);
    chk("ovf_sticky_set", ovf_sticky, 1);
    tick(); tick();
    chk("ovf_sticky_hold", ovf_sticky, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_sticky_clr", ovf_sticky, 0);
    req(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 10);
    tick(); req_valid = 1'b0;
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf_sticky, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    tick();
    // subnormal flush, including after sign flip
    req(32'h80012345, 32'h00400000, 1'b1, 4);
    tick(); req_valid = 1'b0;
    chk("flush_x1", fadd_x1, 32'h80000000);
    chk("flush_x2", fadd_x2, 32'h80000000);
    tick(); tick(); tick();
    // reset with work in flight
    rsp_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      req(32'h3F800000, 32'h3F800000, 1'b0, t);
      tick();
    end
    req_valid = 1'b0;
    chk("pre_rst_valid", rsp_valid, 1);
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_fadd_x1", fadd_x1, 32'h0);
    tick(); tick();
    rstn = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("post_rst_quiet", rsp_valid, 0);
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fadd_issue_ctrl.md
FADD_ISSUE_CTRL -- requirements
Module: fadd_issue_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 2, meaning fadd latency in clock edges from operand presentation to result sampling.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of result FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TAGW, default 5, meaning request tag width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1, req_x1 in 32, req_x2 in 32, req_sub in 1 (1 = x1-x2), req_tag in TAGW.
REQ-007 SHALL have ports fadd_x1 out 32, fadd_x2 out 32, fadd_y in 32, fadd_ovf in 1; these connect to fadd x1, x2, y, ovf.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_y out 32, rsp_ovf out 1, rsp_tag out TAGW.
REQ-009 SHALL have ports ovf_sticky out 1, ovf_clr in 1, busy out 1.

Function
REQ-010 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1 (issue).
REQ-011 SHALL register fadd_x1/fadd_x2 on issue; hold previous values on non-issue cycles.
REQ-012 SHALL drive fadd_x2 = {req_x2[31]^req_sub, req_x2[30:0]}.
REQ-013 SHALL flush subnormal operands: exponent 0 -> mantissa forced to 0, sign kept, applied after sign flip.
REQ-014 SHALL track issue in an NSTAGE-deep valid/tag shift register; operand issued at edge k yields fadd_y/fadd_ovf captured into the FIFO at edge k+NSTAGE.
REQ-015 SHALL support back-to-back issue every cycle; results return in issue order.
REQ-016 SHALL compute req_ready = (fifo_count + inflight_count) < DEPTH from registered counts; a same-cycle FIFO pop does not raise req_ready that cycle.
REQ-017 SHALL never push a full FIFO; push on full is a design error (bench assertion).
REQ-018 SHALL present FIFO head on rsp_y/rsp_ovf/rsp_tag with rsp_valid=1 while FIFO non-empty; pop on rsp_valid & rsp_ready.
REQ-019 SHALL allow push and pop on the same edge at any occupancy including full and empty; count unchanged.
REQ-020 SHALL wrap read/write pointers modulo DEPTH; no bypass: minimum issue-to-rsp_valid latency NSTAGE edges.
REQ-021 SHALL keep rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-022 SHALL set ovf_sticky on edge where a result with fadd_ovf=1 is pushed; clear on ovf_clr=1; set wins on simultaneous set and clear.
REQ-023 SHALL drive busy = any inflight valid | FIFO non-empty.

Reset
REQ-024 SHALL on rstn=0, asynchronously: fadd_x1=fadd_x2=0, all inflight valids 0, FIFO empty, pointers 0, rsp_valid=0, rsp_y=0, rsp_ovf=0, rsp_tag=0, ovf_sticky=0, busy=0.
REQ-025 SHALL discard in-flight operations when reset asserts mid-operation; no response emerges after release.
REQ-026 SHALL drive req_ready=1 during and immediately after reset.

Verification
REQ-027 Bench instantiates fadd_issue_ctrl with fadd (NSTAGE=2); clk/rstn driven as in existing FPU benches.
REQ-028 Add: x1=3F800000, x2=40000000, tag 3 issued at edge k -> rsp_valid from edge k+2, rsp_y=40400000, rsp_tag=3, rsp_ovf=0.
REQ-029 Sub: x1=40400000, x2=3F800000, req_sub=1 -> fadd_x2=BF800000, rsp_y=40000000.
REQ-030 Backpressure: rsp_ready=0, 6 back-to-back requests tags 0..5 -> exactly 4 accepted, req_ready=0; rsp_ready=1 -> tags 0,1,2,3 in order, then 4,5 accepted and returned.
REQ-031 Overflow: 7F7FFFFF+7F7FFFFF -> rsp_ovf=1, ovf_sticky=1 until ovf_clr; ovf_clr coincident with new ovf push -> ovf_sticky stays 1.
REQ-032 Flush: req_x1=80012345 -> fadd_x1=80000000.
REQ-033 Reset mid-op: rstn=0 with 2 inflight and 1 in FIFO -> rsp_valid=0, busy=0 immediately; after release no rsp_valid for 10 cycles without new issue.
